// File: rtl/fetch_sequencer_if.sv
// Bus bundle for the fetch sequencer: the instruction RAM read port
// (im_r/addr/instr_in) and the valid/ready handshake towards decode.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              im_r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] instr_in;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] pc_out;

    modport master (
        output im_r, addr, instr_valid, instr_out, pc_out,
        input  instr_in, instr_ready
    );

    modport slave (
        input  im_r, addr, instr_valid, instr_out, pc_out,
        output instr_in, instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller. Issues one read to a 1-cycle
// registered instruction RAM, captures the word, presents it to decode
// over valid/ready, then moves on. Execute can redirect the PC; fetch
// stops on a HALT opcode or when the PC runs past the end of the RAM.
module fetch_sequencer #(
    parameter int              ADDR_W     = 10,
    parameter int              DATA_W     = 32,
    parameter int              MEM_DEPTH  = 129,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [5:0]      HALT_OP    = 6'b000110,
    parameter int              CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    fetch_sequencer_if.master  bus,
    output logic               busy,
    output logic               halted,
    output logic               fault,
    output logic [CNT_W-1:0]   fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_LATCH,
        S_PRESENT,
        S_HALTED
    } state_t;

    // One extra bit so a depth equal to 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LP_DEPTH = MEM_DEPTH[ADDR_W:0];

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_nextPc;
    logic [ADDR_W-1:0] r_lastAddr;
    logic [DATA_W-1:0] r_instrOut;
    logic [ADDR_W-1:0] r_pcOut;
    logic              r_instrValid;
    logic              r_busy;
    logic              r_halted;
    logic              r_fault;
    logic [CNT_W-1:0]  r_count;

    logic              w_inRange;
    logic              w_isHalt;
    logic              w_imR;
    logic              w_capture;
    logic              w_transfer;
    logic              w_dropValid;
    logic              w_setFault;
    logic              w_clearFault;

    assign w_inRange = ({1'b0, r_pc} < LP_DEPTH);
    assign w_isHalt  = (r_instrOut[DATA_W-1 -: 6] == HALT_OP);

    // Next-state, next-PC and per-cycle action decode. A redirect has
    // priority over everything else in the busy states, including the
    // halt decision, but a transfer in the same cycle still completes.
    always_comb begin
        w_nextState  = r_state;
        w_nextPc     = r_pc;
        w_imR        = 1'b0;
        w_capture    = 1'b0;
        w_transfer   = 1'b0;
        w_dropValid  = 1'b0;
        w_setFault   = 1'b0;
        w_clearFault = 1'b0;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_nextPc     = START_ADDR;
                    w_clearFault = 1'b1;
                    w_nextState  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_imR = w_inRange;
                if (redirect) begin
                    w_nextPc    = redirect_addr;
                    w_nextState = S_ISSUE;
                end else if (!w_inRange) begin
                    w_setFault  = 1'b1;
                    w_nextState = S_HALTED;
                end else begin
                    w_nextState = S_LATCH;
                end
            end
            S_LATCH: begin
                if (redirect) begin
                    w_nextPc    = redirect_addr;
                    w_nextState = S_ISSUE;
                end else begin
                    w_capture   = 1'b1;
                    w_nextPc    = r_pc + 1'b1;
                    w_nextState = S_PRESENT;
                end
            end
            S_PRESENT: begin
                w_transfer = r_instrValid & bus.instr_ready;
                if (redirect) begin
                    w_nextPc    = redirect_addr;
                    w_dropValid = 1'b1;
                    w_nextState = S_ISSUE;
                end else if (w_transfer) begin
                    w_nextState = w_isHalt ? S_HALTED : S_ISSUE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // State, program counter and the address of the last issued read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_pc       <= START_ADDR;
            r_lastAddr <= '0;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            if (w_imR) begin
                r_lastAddr <= r_pc;
            end
        end
    end

    // Capture the RAM word and hold it towards decode until it is taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instrOut   <= '0;
            r_pcOut      <= '0;
            r_instrValid <= 1'b0;
        end else if (w_capture) begin
            r_instrOut   <= bus.instr_in;
            r_pcOut      <= r_pc;
            r_instrValid <= 1'b1;
        end else if (w_transfer || w_dropValid) begin
            r_instrValid <= 1'b0;
        end
    end

    // Saturating count of completed decode transfers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_transfer && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Status flags, registered from the upcoming state; fault is sticky
    // until the next start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_busy   <= (w_nextState == S_ISSUE) || (w_nextState == S_LATCH) ||
                        (w_nextState == S_PRESENT);
            r_halted <= (w_nextState == S_HALTED);
            if (w_setFault) begin
                r_fault <= 1'b1;
            end else if (w_clearFault) begin
                r_fault <= 1'b0;
            end
        end
    end

    assign bus.im_r        = w_imR;
    assign bus.addr        = w_imR ? r_pc : r_lastAddr;
    assign bus.instr_valid = r_instrValid;
    assign bus.instr_out   = r_instrOut;
    assign bus.pc_out      = r_pcOut;
    assign busy            = r_busy;
    assign halted          = r_halted;
    assign fault           = r_fault;
    assign fetch_count     = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer. A behavioural RAM
// and a transaction-level expectation (which PC is fetched next, how many
// transfers have completed) drive every comparison.
module tb_fetch_sequencer;

    localparam int          ADDR_W  = 10;
    localparam int          DATA_W  = 32;
    localparam int          DEPTH   = 129;
    localparam int          CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [5:0]  HALT_OP = 6'b000110;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start;
    logic              redirect;
    logic [ADDR_W-1:0] redirectAddr;
    logic              busy;
    logic              halted;
    logic              fault;
    logic [CNT_W-1:0]  fetchCount;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] ramQ;

    int vectors     = 0;
    int miscompares = 0;
    int mCount      = 0;

    fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_DEPTH  (DEPTH),
        .START_ADDR (10'd0),
        .HALT_OP    (HALT_OP),
        .CNT_W      (CNT_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .redirect      (redirect),
        .redirect_addr (redirectAddr),
        .bus           (bus),
        .busy          (busy),
        .halted        (halted),
        .fault         (fault),
        .fetch_count   (fetchCount)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Behavioural instruction RAM: one-cycle registered read, holds when idle.
    always @(posedge clock) begin
        if (bus.im_r) begin
            ramQ <= (int'(bus.addr) < DEPTH) ? mem[bus.addr] : '0;
        end
    end
    assign bus.instr_in = ramQ;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == HALT_OP) w[26] = ~w[26];
        return w;
    endfunction

    function automatic int satInc(input int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    task automatic expectIssue(input logic [ADDR_W-1:0] pc);
        checkVal("issue_imr",   bus.im_r, 1);
        checkVal("issue_addr",  bus.addr, pc);
        checkVal("issue_busy",  busy, 1);
        checkVal("issue_valid", bus.instr_valid, 0);
    endtask

    task automatic expectPresent(input logic [ADDR_W-1:0] pc);
        checkVal("present_valid", bus.instr_valid, 1);
        checkVal("present_instr", bus.instr_out, mem[pc]);
        checkVal("present_pc",    bus.pc_out, pc);
        checkVal("present_imr",   bus.im_r, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_imr"},    bus.im_r, 0);
        checkVal({tag, "_addr"},   bus.addr, 0);
        checkVal({tag, "_valid"},  bus.instr_valid, 0);
        checkVal({tag, "_instr"},  bus.instr_out, 0);
        checkVal({tag, "_pcout"},  bus.pc_out, 0);
        checkVal({tag, "_busy"},   busy, 0);
        checkVal({tag, "_halted"}, halted, 0);
        checkVal({tag, "_fault"},  fault, 0);
        checkVal({tag, "_count"},  fetchCount, 0);
    endtask

    // Full fetch of one word with instr_ready held high; starts in ISSUE.
    task automatic doFetch(input logic [ADDR_W-1:0] pc);
        expectIssue(pc);
        tick();
        checkVal("latch_imr",   bus.im_r, 0);
        checkVal("latch_addr",  bus.addr, pc);
        checkVal("latch_valid", bus.instr_valid, 0);
        tick();
        expectPresent(pc);
        tick();
        mCount = satInc(mCount);
        checkVal("xfer_count", fetchCount, mCount);
        checkVal("xfer_valid", bus.instr_valid, 0);
    endtask

    // Directed scenarios followed by a randomized run to saturation.
    initial begin
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
        int                stalls;
        bit                doRedir;

        for (int i = 0; i < DEPTH; i++) mem[i] = randWord();
        mem[0]  = 32'h27C0_0000;
        mem[1]  = 32'h3800_0003;
        mem[86] = 32'h1800_0000;

        reset_n         = 1'b1;
        start           = 1'b0;
        redirect        = 1'b0;
        redirectAddr    = '0;
        bus.instr_ready = 1'b0;

        // Reset values.
        #2 reset_n = 1'b0;
        #1 checkAllZero("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checkVal("idle_busy", busy, 0);

        // Basic fetch: start, two words, 3-cycle latency and throughput.
        bus.instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        doFetch(10'd0);
        doFetch(10'd1);

        // Backpressure on word 2.
        bus.instr_ready = 1'b0;
        expectIssue(10'd2);
        tick();
        tick();
        expectPresent(10'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            expectPresent(10'd2);
            checkVal("stall_count", fetchCount, mCount);
        end
        bus.instr_ready = 1'b1;
        tick();
        mCount = satInc(mCount);
        checkVal("stall_release_count", fetchCount, mCount);

        // Redirect during LATCH of pc 3: word 3 is dropped.
        expectIssue(10'd3);
        tick();
        redirect = 1'b1;
        redirectAddr = 10'h00A;
        tick();
        redirect = 1'b0;
        checkVal("redir_latch_count", fetchCount, mCount);
        doFetch(10'h00A);

        // Redirect together with a transfer in PRESENT.
        target = 10'($urandom_range(30, 60));
        expectIssue(10'd11);
        tick();
        tick();
        expectPresent(10'd11);
        redirect = 1'b1;
        redirectAddr = target;
        tick();
        redirect = 1'b0;
        mCount = satInc(mCount);
        checkVal("redir_xfer_count", fetchCount, mCount);
        doFetch(target);

        // Redirect overrides the halt decision on the HALT word.
        redirect = 1'b1;
        redirectAddr = 10'd86;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        expectPresent(10'd86);
        redirect = 1'b1;
        redirectAddr = 10'd20;
        tick();
        redirect = 1'b0;
        mCount = satInc(mCount);
        checkVal("halt_override_count", fetchCount, mCount);
        checkVal("halt_override_halted", halted, 0);
        doFetch(10'd20);

        // Redirect while issuing, then run into the HALT word at 86.
        redirect = 1'b1;
        redirectAddr = 10'd85;
        tick();
        redirect = 1'b0;
        checkVal("redir_issue_count", fetchCount, mCount);
        doFetch(10'd85);
        doFetch(10'd86);
        checkVal("halt_halted", halted, 1);
        checkVal("halt_busy", busy, 0);
        redirect = 1'b1;
        redirectAddr = 10'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal("halt_imr", bus.im_r, 0);
            checkVal("halt_stay", halted, 1);
        end
        redirect = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkVal("restart_fault", fault, 0);
        checkVal("restart_count", fetchCount, mCount);
        doFetch(10'd0);

        // Last valid word, then PC runs off the end of the RAM.
        redirect = 1'b1;
        redirectAddr = 10'd128;
        tick();
        redirect = 1'b0;
        doFetch(10'd128);
        checkVal("fault_noimr", bus.im_r, 0);
        tick();
        checkVal("fault_flag", fault, 1);
        checkVal("fault_halted", halted, 1);
        checkVal("fault_valid", bus.instr_valid, 0);
        checkVal("fault_busy", busy, 0);
        checkVal("fault_imr", bus.im_r, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkVal("fault_clear", fault, 0);
        expectIssue(10'd0);

        // Asynchronous reset in the middle of LATCH.
        tick();
        #2 reset_n = 1'b0;
        #1 checkAllZero("async");
        mCount = 0;
        tick();
        reset_n = 1'b1;
        redirect = 1'b1;
        redirectAddr = 10'd5;
        tick();
        tick();
        checkVal("idle_redir_busy", busy, 0);
        checkVal("idle_redir_imr", bus.im_r, 0);
        redirectAddr = 10'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        redirect = 1'b0;

        // Random stalls and redirects until the counter saturates.
        pc = 10'd0;
        for (int i = 0; i < 20; i++) begin
            stalls  = $urandom_range(0, 3);
            doRedir = ($urandom_range(0, 3) == 0);
            target  = 10'($urandom_range(0, 60));
            expectIssue(pc);
            tick();
            tick();
            expectPresent(pc);
            bus.instr_ready = 1'b0;
            for (int s = 0; s < stalls; s++) begin
                tick();
                expectPresent(pc);
            end
            bus.instr_ready = 1'b1;
            redirect = doRedir;
            redirectAddr = target;
            tick();
            redirect = 1'b0;
            mCount = satInc(mCount);
            checkVal("rand_count", fetchCount, mCount);
            pc = doRedir ? target : 10'((int'(pc) + 1) % (1 << ADDR_W));
        end
        checkVal("saturated", fetchCount, CNT_MAX);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
